// File: rtl/key_expand_seq_if.sv
// Round-key stream between the key expander (master) and the cipher datapath (slave).
interface key_expand_seq_if;
  logic         rk_valid;
  logic         rk_ready;
  logic [3:0]   rk_round;
  logic [127:0] rk_data;

  modport master (output rk_valid, output rk_round, output rk_data, input rk_ready);
  modport slave  (input rk_valid, input rk_round, input rk_data, output rk_ready);
endinterface

// File: rtl/key_expand_seq.sv
// Sequential AES-128/256 key expansion: one schedule word per cycle, SubWord via an
// external one-cycle S-box, 128-bit round keys streamed over valid/ready.
module key_expand_seq #(
  parameter int unsigned KEY_W    = 256,
  parameter int unsigned SBOX_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               key_type,
  input  logic [KEY_W-1:0]   key_in,
  output logic [31:0]        sbox_addr,
  input  logic [31:0]        sbox_data,
  output logic               busy,
  output logic               done,
  key_expand_seq_if.master   rk
);

  if (SBOX_LAT != 1) begin : g_unsupported_sbox_lat
  end

  typedef enum logic [1:0] {StIdle, StGen, StSub, StEmit} state_e;

  state_e             state_q, state_d;
  logic [5:0]         idx_q, idx_d;
  logic [7:0]         rcon_q, rcon_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic               aes256_q, aes256_d;
  logic [31:0]        sbox_addr_q, sbox_addr_d;
  logic [127:0]       rk_data_q, rk_data_d;
  logic [3:0]         rk_round_q, rk_round_d;
  logic               rk_valid_q, rk_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  // win_q[0] is w[i-1], win_q[k] is w[i-1-k]
  logic [31:0]        win_q [8];

  logic               wr_en;
  logic [31:0]        wr_word;
  logic [31:0]        temp;
  logic [31:0]        w_prev, w_nk, key_word;
  logic               below_nk, rcon_path, sub_only, last_round;

  assign w_prev     = win_q[0];
  assign w_nk       = aes256_q ? win_q[7] : win_q[3];
  assign key_word   = key_q[{3'd7 - idx_q[2:0], 5'd0} +: 32];
  assign below_nk   = aes256_q ? (idx_q < 6'd8) : (idx_q < 6'd4);
  assign rcon_path  = aes256_q ? (idx_q[2:0] == 3'd0) : (idx_q[1:0] == 2'd0);
  assign sub_only   = aes256_q && (idx_q[2:0] == 3'd4);
  assign last_round = (rk_round_q == (aes256_q ? 4'd14 : 4'd10));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rcon_d      = rcon_q;
    key_d       = key_q;
    aes256_d    = aes256_q;
    sbox_addr_d = sbox_addr_q;
    rk_data_d   = rk_data_q;
    rk_round_d  = rk_round_q;
    rk_valid_d  = rk_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    wr_en       = 1'b0;
    temp        = 32'h0;
    wr_word     = w_nk ^ w_prev;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          key_d    = key_in;
          aes256_d = key_type;
          idx_d    = 6'd0;
          rcon_d   = 8'h01;
          busy_d   = 1'b1;
          state_d  = StGen;
        end
      end
      StGen: begin
        if (below_nk) begin
          wr_en   = 1'b1;
          wr_word = key_word;
        end else if (rcon_path) begin
          sbox_addr_d = {w_prev[23:0], w_prev[31:24]};
          state_d     = StSub;
        end else if (sub_only) begin
          sbox_addr_d = w_prev;
          state_d     = StSub;
        end else begin
          wr_en = 1'b1;
        end
      end
      StSub: begin
        wr_en   = 1'b1;
        temp    = sbox_data ^ (rcon_path ? {rcon_q, 24'h0} : 32'h0);
        wr_word = w_nk ^ temp;
        if (rcon_path) begin
          rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        end
      end
      StEmit: begin
        if (rk.rk_ready) begin
          rk_valid_d = 1'b0;
          if (last_round) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end else begin
            state_d = StGen;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Writing the last word of a group publishes the round key and stalls in EMIT.
    if (wr_en) begin
      idx_d = idx_q + 6'd1;
      if (idx_q[1:0] == 2'b11) begin
        rk_data_d  = {win_q[2], win_q[1], win_q[0], wr_word};
        rk_round_d = idx_q[5:2];
        rk_valid_d = 1'b1;
        state_d    = StEmit;
      end else begin
        state_d = StGen;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= 6'd0;
      rcon_q      <= 8'h01;
      key_q       <= '0;
      aes256_q    <= 1'b0;
      sbox_addr_q <= 32'h0;
      rk_data_q   <= 128'h0;
      rk_round_q  <= 4'd0;
      rk_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        win_q[k] <= 32'h0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rcon_q      <= rcon_d;
      key_q       <= key_d;
      aes256_q    <= aes256_d;
      sbox_addr_q <= sbox_addr_d;
      rk_data_q   <= rk_data_d;
      rk_round_q  <= rk_round_d;
      rk_valid_q  <= rk_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      if (wr_en) begin
        win_q[0] <= wr_word;
        for (int k = 1; k < 8; k++) begin
          win_q[k] <= win_q[k-1];
        end
      end
    end
  end

  assign sbox_addr   = sbox_addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign rk.rk_valid = rk_valid_q;
  assign rk.rk_round = rk_round_q;
  assign rk.rk_data  = rk_data_q;

endmodule

// File: tb/tb_key_expand_seq.sv
// Bench for key_expand_seq: FIPS-197 known answers plus randomized runs against a
// straightforward software key-schedule model.
module tb_key_expand_seq;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         key_type = 1'b0;
  logic [255:0] key_in = '0;
  logic [31:0]  sbox_addr;
  logic [31:0]  sbox_data;
  logic         busy;
  logic         done;

  key_expand_seq_if rk_if ();

  key_expand_seq #(.KEY_W(256), .SBOX_LAT(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .key_type  (key_type),
    .key_in    (key_in),
    .sbox_addr (sbox_addr),
    .sbox_data (sbox_data),
    .busy      (busy),
    .done      (done),
    .rk        (rk_if)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  localparam logic [255:0] Key128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] Key256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse (x^254) then the affine map.
  function automatic logic [7:0] sbox_byte(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    for (int k = 0; k < 254; k++) inv = gmul(inv, x);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_byte(w[31:24]), sbox_byte(w[23:16]), sbox_byte(w[15:8]), sbox_byte(w[7:0])};
  endfunction

  assign sbox_data = sub_word(sbox_addr);

  logic [31:0]  mw [60];
  logic [127:0] exp_rk [15];
  int           exp_n;

  task automatic model_expand(input logic [255:0] key, input logic t);
    int nk;
    int nw;
    logic [31:0] tmp;
    logic [7:0] rc;
    nk = t ? 8 : 4;
    nw = t ? 60 : 44;
    rc = 8'h01;
    for (int i = 0; i < nw; i++) begin
      if (i < nk) begin
        mw[i] = key[255 - 32*i -: 32];
      end else begin
        tmp = mw[i-1];
        if (i % nk == 0) begin
          tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk == 8 && i % 8 == 4) begin
          tmp = sub_word(tmp);
        end
        mw[i] = mw[i-nk] ^ tmp;
      end
    end
    exp_n = nw / 4;
    for (int r = 0; r < exp_n; r++) exp_rk[r] = {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endtask

  function automatic logic [255:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- stimulus helpers ----------------
  logic [127:0] got_rk [16];
  logic [3:0]   got_round [16];
  int           got_n;
  int           run_cyc;
  bit           timed_out;
  bit           stall_ok;
  bit           stall_seen;

  task automatic do_start(input logic [255:0] key, input logic t);
    @(negedge clk);
    key_in = key;
    key_type = t;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: ready=1, 1: random ready, 2: 5-cycle stall at stall_round, 3: garbage inputs
  task automatic collect(input int mode, input int stall_round);
    logic [127:0] snap_data;
    logic [3:0]   snap_round;
    logic [31:0]  snap_addr;
    int  stall_cnt;
    bit  nxt_ready;
    bit  fin;
    got_n = 0; run_cyc = 0; timed_out = 0; stall_ok = 1; stall_seen = 0;
    stall_cnt = 0; fin = 0;
    snap_data = '0; snap_round = '0; snap_addr = '0;
    while (!fin) begin
      @(negedge clk);
      run_cyc++;
      if (done) begin
        fin = 1;
      end else if (run_cyc > 1000) begin
        timed_out = 1;
        fin = 1;
      end else begin
        nxt_ready = 1'b1;
        if (mode == 1) nxt_ready = ($urandom_range(0, 2) != 0);
        if (mode == 2 && rk_if.rk_valid && rk_if.rk_round == 4'(stall_round) && stall_cnt <= 5)
        begin
          if (stall_cnt == 0) begin
            snap_data = rk_if.rk_data; snap_round = rk_if.rk_round; snap_addr = sbox_addr;
          end else if (rk_if.rk_data !== snap_data || rk_if.rk_round !== snap_round ||
                       sbox_addr !== snap_addr) begin
            stall_ok = 0;
          end
          nxt_ready = (stall_cnt == 5);
          if (stall_cnt == 5) stall_seen = 1;
          stall_cnt++;
        end
        if (mode == 3) begin
          start = 1'($urandom_range(0, 1));
          key_type = 1'($urandom_range(0, 1));
          key_in = rand_key();
        end
        rk_if.rk_ready = nxt_ready;
        if (rk_if.rk_valid && nxt_ready && got_n < 16) begin
          got_rk[got_n] = rk_if.rk_data;
          got_round[got_n] = rk_if.rk_round;
          got_n++;
        end
      end
    end
    start = 1'b0;
    rk_if.rk_ready = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    rk_if.rk_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_total++; if (rk_if.rk_valid !== 1'b0) $display("FAIL reset_rk_valid got %b want 0", rk_if.rk_valid); else n_pass++;
    n_total++; if (rk_if.rk_round !== 4'd0) $display("FAIL reset_rk_round got %0d want 0", rk_if.rk_round); else n_pass++;
    n_total++; if (rk_if.rk_data !== 128'h0) $display("FAIL reset_rk_data got %h want 0", rk_if.rk_data); else n_pass++;
    n_total++; if (sbox_addr !== 32'h0) $display("FAIL reset_sbox_addr got %h want 0", sbox_addr); else n_pass++;
    n_total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy_done got %b%b want 00", busy, done); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_sbox_timing();
    logic [31:0]  addr_log [13];
    logic         v_log [13];
    logic [3:0]   r_log [13];
    logic [127:0] d_log [13];
    model_expand(Key128, 1'b0);
    do_start(Key128, 1'b0);
    rk_if.rk_ready = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      addr_log[c] = sbox_addr; v_log[c] = rk_if.rk_valid; r_log[c] = rk_if.rk_round;
      d_log[c] = rk_if.rk_data;
    end
    n_total++; if (addr_log[5] !== 32'h0) $display("FAIL sbox_addr_early got %h want 0", addr_log[5]); else n_pass++;
    n_total++; if (addr_log[6] !== 32'hcf4f3c09) $display("FAIL sbox_addr_word4 got %h want cf4f3c09", addr_log[6]); else n_pass++;
    n_total++; if (v_log[4] !== 1'b1 || d_log[4] !== Key128[255:128]) $display("FAIL rk0_timing got v=%b %h want v=1 %h", v_log[4], d_log[4], Key128[255:128]); else n_pass++;
    n_total++; if (v_log[9] !== 1'b0) $display("FAIL rk1_not_early got v=%b want 0", v_log[9]); else n_pass++;
    n_total++; if (v_log[10] !== 1'b1 || r_log[10] !== 4'd1 || d_log[10] !== exp_rk[1]) $display("FAIL rk1_timing got v=%b r=%0d %h want v=1 r=1 %h", v_log[10], r_log[10], d_log[10], exp_rk[1]); else n_pass++;
    collect(0, 0);
    n_total++; if (timed_out) $display("FAIL sbox_drain_timeout got no done want done"); else n_pass++;
  endtask

  task automatic test_aes128_kat();
    model_expand(Key128, 1'b0);
    do_start(Key128, 1'b0);
    collect(0, 0);
    n_total++; if (timed_out || run_cyc !== 65) $display("FAIL aes128_latency got %0d want 65", run_cyc); else n_pass++;
    n_total++; if (got_n !== 11) $display("FAIL aes128_count got %0d want 11", got_n); else n_pass++;
    n_total++; if (got_rk[0] !== 128'h2b7e151628aed2a6abf7158809cf4f3c) $display("FAIL aes128_rk0 got %h want 2b7e151628aed2a6abf7158809cf4f3c", got_rk[0]); else n_pass++;
    n_total++; if (got_rk[1] !== 128'ha0fafe1788542cb123a339392a6c7605) $display("FAIL aes128_rk1 got %h want a0fafe1788542cb123a339392a6c7605", got_rk[1]); else n_pass++;
    n_total++; if (got_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) $display("FAIL aes128_rk10 got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", got_rk[10]); else n_pass++;
    for (int r = 0; r < got_n && r < exp_n; r++) begin
      n_total++; if (got_rk[r] !== exp_rk[r] || got_round[r] !== 4'(r)) $display("FAIL aes128_model r%0d got %0d %h want %0d %h", r, got_round[r], got_rk[r], r, exp_rk[r]); else n_pass++;
    end
    n_total++; if (busy !== 1'b0) $display("FAIL aes128_busy_end got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_aes256_kat();
    model_expand(Key256, 1'b1);
    do_start(Key256, 1'b1);
    collect(0, 0);
    n_total++; if (timed_out || run_cyc !== 88) $display("FAIL aes256_latency got %0d want 88", run_cyc); else n_pass++;
    n_total++; if (got_n !== 15) $display("FAIL aes256_count got %0d want 15", got_n); else n_pass++;
    n_total++; if (got_rk[2] !== 128'h9ba354118e6925afa51a8b5f2067fcde) $display("FAIL aes256_rk2 got %h want 9ba354118e6925afa51a8b5f2067fcde", got_rk[2]); else n_pass++;
    n_total++; if (got_rk[3][127:96] !== 32'ha8b09c1a) $display("FAIL aes256_rk3_w12 got %h want a8b09c1a", got_rk[3][127:96]); else n_pass++;
    n_total++; if (got_rk[14] !== 128'hfe4890d1e6188d0b046df344706c631e) $display("FAIL aes256_rk14 got %h want fe4890d1e6188d0b046df344706c631e", got_rk[14]); else n_pass++;
    for (int r = 0; r < got_n && r < exp_n; r++) begin
      n_total++; if (got_rk[r] !== exp_rk[r] || got_round[r] !== 4'(r)) $display("FAIL aes256_model r%0d got %0d %h want %0d %h", r, got_round[r], got_rk[r], r, exp_rk[r]); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    model_expand(Key128, 1'b0);
    do_start(Key128, 1'b0);
    collect(2, 3);
    n_total++; if (!stall_seen || !stall_ok) $display("FAIL bp_frozen got seen=%b stable=%b want 1 1", stall_seen, stall_ok); else n_pass++;
    n_total++; if (timed_out || run_cyc !== 70) $display("FAIL bp_latency got %0d want 70", run_cyc); else n_pass++;
    n_total++; if (got_n !== 11) $display("FAIL bp_count got %0d want 11", got_n); else n_pass++;
    for (int r = 0; r < got_n && r < exp_n; r++) begin
      n_total++; if (got_rk[r] !== exp_rk[r] || got_round[r] !== 4'(r)) $display("FAIL bp_model r%0d got %0d %h want %0d %h", r, got_round[r], got_rk[r], r, exp_rk[r]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    logic [255:0] k;
    do_start(Key128, 1'b0);
    rk_if.rk_ready = 1'b1;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (rk_if.rk_valid && rk_if.rk_round == 4'd5) found = 1;
    end
    n_total++; if (!found) $display("FAIL rstmid_reach_rk5 got none want rk5"); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_total++; if (rk_if.rk_valid !== 1'b0 || rk_if.rk_round !== 4'd0 || rk_if.rk_data !== 128'h0) $display("FAIL rstmid_rk got v=%b r=%0d %h want 0 0 0", rk_if.rk_valid, rk_if.rk_round, rk_if.rk_data); else n_pass++;
    n_total++; if (sbox_addr !== 32'h0 || busy !== 1'b0 || done !== 1'b0) $display("FAIL rstmid_ctrl got %h %b %b want 0 0 0", sbox_addr, busy, done); else n_pass++;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL reset_beats_start got busy=%b want 0", busy); else n_pass++;
    reset = 1'b0;
    k = rand_key();
    model_expand(k, 1'b0);
    do_start(k, 1'b0);
    collect(0, 0);
    n_total++; if (timed_out || got_n !== 11) $display("FAIL rstmid_fresh_count got %0d want 11", got_n); else n_pass++;
    for (int r = 0; r < got_n && r < exp_n; r++) begin
      n_total++; if (got_rk[r] !== exp_rk[r] || got_round[r] !== 4'(r)) $display("FAIL rstmid_model r%0d got %0d %h want %0d %h", r, got_round[r], got_rk[r], r, exp_rk[r]); else n_pass++;
    end
  endtask

  task automatic test_start_ignored();
    model_expand(Key128, 1'b0);
    do_start(Key128, 1'b0);
    collect(3, 0);
    n_total++; if (timed_out || run_cyc !== 65) $display("FAIL ign_latency got %0d want 65", run_cyc); else n_pass++;
    n_total++; if (got_n !== 11) $display("FAIL ign_count got %0d want 11", got_n); else n_pass++;
    for (int r = 0; r < got_n && r < exp_n; r++) begin
      n_total++; if (got_rk[r] !== exp_rk[r] || got_round[r] !== 4'(r)) $display("FAIL ign_model r%0d got %0d %h want %0d %h", r, got_round[r], got_rk[r], r, exp_rk[r]); else n_pass++;
    end
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL ign_idle_after got busy=%b want 0", busy); else n_pass++;
  endtask

  task automatic test_random();
    logic [255:0] k;
    logic t;
    for (int run = 0; run < 6; run++) begin
      k = rand_key();
      t = 1'($urandom_range(0, 1));
      model_expand(k, t);
      do_start(k, t);
      collect(1, 0);
      n_total++; if (timed_out || got_n !== exp_n) $display("FAIL rand%0d_count got %0d want %0d", run, got_n, exp_n); else n_pass++;
      for (int r = 0; r < got_n && r < exp_n; r++) begin
        n_total++; if (got_rk[r] !== exp_rk[r] || got_round[r] !== 4'(r)) $display("FAIL rand%0d_model r%0d got %0d %h want %0d %h", run, r, got_round[r], got_rk[r], r, exp_rk[r]); else n_pass++;
      end
    end
  endtask

  initial begin
    rk_if.rk_ready = 1'b1;
    test_reset();
    test_sbox_timing();
    test_aes128_kat();
    test_aes256_kat();
    test_backpressure();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/key_expand_seq.md
Name: key_expand_seq

Overview:
- Sequential AES key-expansion engine for AES-128 and AES-256.
- Generates the round-key words w[i] one at a time and streams 128-bit round keys to the cipher datapath over a valid/ready handshake.
- Applies RotWord, SubWord and Rcon itself; SubWord goes through an external S-box word lookup with one clock of latency (four byte S-boxes).
- Sits between key load and the round datapath, replacing free-running Rcon counters with index-driven control.

Parameters:
- KEY_W, 256, width of key_in (fixed at 256; AES-128 uses the upper 128 bits).
- SBOX_LAT, 1, cycles from sbox_addr change to valid sbox_data (only value 1 supported).

Ports:
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  begin expansion; sampled only in IDLE.
- type  input  1  0 = AES-128 (Nk=4, 11 round keys), 1 = AES-256 (Nk=8, 15 round keys); sampled with start.
- key_in  input  256  cipher key, w0 in bits 255:224; AES-128 uses bits 255:128.
- sbox_addr  output  32  registered word to substitute (bytewise S-box).
- sbox_data  input  32  S-box result, valid one cycle after sbox_addr is loaded.
- rk_valid  output  1  round key available.
- rk_ready  input  1  consumer accepts round key.
- rk_round  output  4  round index of rk_data, 0..10 or 0..14.
- rk_data  output  128  round key, w[4r] in bits 127:96.
- busy  output  1  expansion in progress.
- done  output  1  one-cycle pulse after the last round key is accepted.

Behaviour:
- Reset values:
  - Outputs: rk_valid=0, rk_round=0, rk_data=0, sbox_addr=0, busy=0, done=0.
  - Internal: FSM=IDLE, word index i=0, rcon=8'h01, all word registers 0.
- States: IDLE, GEN, SUB, EMIT.
- IDLE:
  - start=1: latch key_in and type, i=0, rcon=01, busy=1 next cycle, go to GEN.
  - start while busy is ignored.
- GEN (one cycle per word):
  - i<Nk: w[i] = key word i.
  - i%Nk==0 (i>=Nk): sbox_addr <= RotWord(w[i-1]), i.e. {w[23:0],w[31:24]}; go to SUB.
  - type=1 and i%8==4: sbox_addr <= w[i-1]; go to SUB.
  - Otherwise: w[i] = w[i-Nk] ^ w[i-1].
- SUB (one cycle):
  - temp = sbox_data, XOR {rcon,24'h0} on the Rcon path only.
  - w[i] = w[i-Nk] ^ temp.
  - On the Rcon path, rcon <= xtime(rcon): 80 -> 1b.
  - Return to GEN with i+1.
- Word window: the block keeps the last 8 words (4 used for AES-128) for the w[i-Nk] and w[i-1] terms.
- Group completion: when i%4==3 is written, load rk_data with {w[i-3],w[i-2],w[i-1],w[i]}, set rk_round=i/4, rk_valid=1, go to EMIT.
- EMIT:
  - Hold rk_data, rk_round and rk_valid stable until the cycle where rk_valid & rk_ready.
  - On that handshake, rk_valid drops next cycle.
  - If the last round (10 or 14): done=1 for one cycle, busy=0, go to IDLE.
  - Else: continue in GEN at i+1.
- No word is generated while in EMIT (backpressure stalls expansion).
- Latency with rk_ready held 1:
  - Each word takes 1 cycle, plus 1 per SUB, plus 1 EMIT per round key.
  - AES-128: 44+10+11 = 65 cycles from the start-sampling edge to the done edge.
  - AES-256: 60+13+15 = 88 cycles.
- Rcon usage: AES-128 ends at 36 (10 uses); AES-256 ends at 40 (7 uses).
- All word arithmetic is 32-bit XOR, with no carries.
- Reset mid-operation: the next edge returns to the reset values; the partial schedule is discarded and rk_valid drops immediately.
- reset together with start: reset wins.
- type and key_in changes while busy have no effect.

Test Plan:
1. AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> rk0=key, rk1=a0fafe1788542cb123a339392a6c7605, rk10=d014f9a8c9ee2589e13f0cc8b6630ca6, done exactly 65 cycles after start.
2. AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> rk2=9ba354118e6925afa51a8b5f2067fcde, rk3 first word a8b09c1a (SubWord-only path), rk14=fe4890d1e6188d0b046df344706c631e, done 88 cycles after start.
3. Backpressure: rk_ready=0 for 5 cycles at rk3 -> rk_data/rk_round frozen, sbox_addr unchanged, no words advance; final keys identical to scenario 1.
4. Reset asserted mid-expansion at rk5 -> all outputs 0 next cycle; a following start produces a fresh, correct rk0..rk10.
5. start pulsed while busy, and type toggled mid-run -> ignored; output sequence matches scenario 1.
6. S-box timing: check sbox_addr = 09cf4f3c rotated to cf4f3c09 on word 4, and sbox_data consumed exactly one cycle later.
